// File: rtl/gbar_unit_pkg.sv
// Shared sizing for the global barrier unit: barrier and core counts and
// the ID widths derived from them.
package gbar_unit_pkg;

    // Bit width needed to index n items. It never drops below 1, so that a
    // single-item ID field still gets a real bit.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_NUM_BARRIERS = 4;
    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NB_WIDTH     = log2up(GBAR_NUM_BARRIERS);
    localparam int GBAR_NC_WIDTH     = log2up(GBAR_NUM_CORES);

endpackage

// File: rtl/gbar_unit_if.sv
// Arrival request / release broadcast bus between the barrier arbiters and
// the global barrier unit.
interface gbar_unit_if
    import gbar_unit_pkg::*;
#(
    parameter int NB_WIDTH = GBAR_NB_WIDTH,
    parameter int NC_WIDTH = GBAR_NC_WIDTH
);
    logic                req_valid;
    logic [NB_WIDTH-1:0] req_id;
    logic [NC_WIDTH-1:0] req_size_m1;
    logic [NC_WIDTH-1:0] req_core_id;
    logic                req_ready;
    logic                rsp_valid;
    logic [NB_WIDTH-1:0] rsp_id;
    logic                err_dup;

    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input  req_ready, rsp_valid, rsp_id, err_dup
    );

    modport slave (
        input  req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id, err_dup
    );
endinterface

// File: rtl/gbar_unit_popcount.sv
// Counts the set bits of an arrival mask. The result is purely combinational.
module gbar_unit_popcount
    import gbar_unit_pkg::*;
#(
    parameter int N  = GBAR_NUM_CORES,
    parameter int CW = GBAR_NC_WIDTH + 1
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] cnt_o
);

    // Add up the mask bits one at a time.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/gbar_unit.sv
// Global barrier unit. It records which cores have reached each barrier ID
// and broadcasts a one-cycle release once the expected number have arrived.
module gbar_unit
    import gbar_unit_pkg::*;
#(
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
    parameter int NUM_CORES    = GBAR_NUM_CORES,
    parameter int NB_WIDTH     = log2up(NUM_BARRIERS),
    parameter int NC_WIDTH     = log2up(NUM_CORES)
) (
    input  logic        clk,
    input  logic        reset,
    gbar_unit_if.slave  gbar_if
);

    // One extra bit, so that a size_m1 with every bit set still compares
    // correctly against the arrival count.
    localparam int CNT_W = NC_WIDTH + 1;

    logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_d [NUM_BARRIERS];
    logic                 rsp_valid_q, rsp_valid_d;
    logic [NB_WIDTH-1:0]  rsp_id_q, rsp_id_d;
    logic                 err_dup_q, err_dup_d;

    logic                 req_ready;
    logic                 fire;
    logic [NUM_CORES-1:0] mask_cur;
    logic [NUM_CORES-1:0] core_bit;
    logic [NUM_CORES-1:0] next_mask;
    logic                 dup;
    logic [CNT_W-1:0]     arrived_cnt;
    logic [CNT_W-1:0]     target_cnt;
    logic                 release_now;

    assign req_ready = ~reset;
    assign fire      = gbar_if.req_valid & req_ready;

    assign mask_cur    = mask_q[gbar_if.req_id];
    assign core_bit    = NUM_CORES'(1) << gbar_if.req_core_id;
    assign next_mask   = mask_cur | core_bit;
    assign dup         = |(mask_cur & core_bit);
    assign target_cnt  = CNT_W'(gbar_if.req_size_m1) + CNT_W'(1);

    gbar_unit_popcount #(
        .N  (NUM_CORES),
        .CW (CNT_W)
    ) u_popcount (
        .bits_i (next_mask),
        .cnt_o  (arrived_cnt)
    );

    // The size carried by the completing arrival decides the release.
    // A repeated arrival never completes a barrier.
    assign release_now = fire & ~dup & (arrived_cnt == target_cnt);

    // Update the addressed mask and prepare the registered outputs.
    always_comb begin
        mask_d      = mask_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        err_dup_d   = 1'b0;
        if (fire) begin
            if (dup) begin
                err_dup_d = 1'b1;
            end else if (release_now) begin
                mask_d[gbar_if.req_id] = '0;
                rsp_valid_d            = 1'b1;
                rsp_id_d               = gbar_if.req_id;
            end else begin
                mask_d[gbar_if.req_id] = next_mask;
            end
        end
    end

    // State registers. Reset discards partial masks and any pending release.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_q[b] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            err_dup_q   <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            err_dup_q   <= err_dup_d;
        end
    end

    assign gbar_if.req_ready = req_ready;
    assign gbar_if.rsp_valid = rsp_valid_q;
    assign gbar_if.rsp_id    = rsp_id_q;
    assign gbar_if.err_dup   = err_dup_q;

    // An arriving core ID must name a real core.
    a_core_id_range : assert property (
        @(posedge clk) disable iff (reset)
        fire |-> (int'(gbar_if.req_core_id) < NUM_CORES)
    );

endmodule

// File: tb/tb_gbar_unit.sv
// Self-checking bench for gbar_unit: directed scenarios plus a random soak,
// scored against a per-barrier arrival-set model.
module tb_gbar_unit;
    import gbar_unit_pkg::*;

    localparam int NB  = GBAR_NUM_BARRIERS;
    localparam int NC  = GBAR_NUM_CORES;
    localparam int NBW = GBAR_NB_WIDTH;
    localparam int NCW = GBAR_NC_WIDTH;

    typedef struct {
        bit rel;
        bit dup;
        int id;
    } exp_t;

    logic clk;
    logic reset;

    gbar_unit_if bus_if ();

    gbar_unit dut (
        .clk     (clk),
        .reset   (reset),
        .gbar_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   arrived [NB][NC];
    int   soak_size [NB];
    int   model_rel = 0;
    int   dut_rel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int members(input int id);
        int n = 0;
        for (int c = 0; c < NC; c++) n += arrived[id][c] ? 1 : 0;
        return n;
    endfunction

    // Arrival rules: a repeat is flagged and ignored; otherwise the core joins
    // the set, and when the set reaches size_m1+1 members the barrier releases
    // and starts empty again.
    function automatic void model_arrive(input int id, input int sz, input int core);
        exp_t e;
        e.rel = 0; e.dup = 0; e.id = id;
        if (arrived[id][core]) begin
            e.dup = 1;
        end else begin
            arrived[id][core] = 1;
            if (members(id) == sz + 1) begin
                e.rel = 1;
                model_rel++;
                for (int c = 0; c < NC; c++) arrived[id][c] = 0;
            end
        end
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NC; c++) arrived[b][c] = 0;
    endfunction

    task automatic arrive(input int id, input int sz, input int core);
        @(negedge clk);
        bus_if.req_valid   = 1'b1;
        bus_if.req_id      = NBW'(id);
        bus_if.req_size_m1 = NCW'(sz);
        bus_if.req_core_id = NCW'(core);
        model_arrive(id, sz, core);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.req_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: just after each edge, compare the outputs with the next queued
    // expectation when an arrival fired, otherwise expect the outputs quiet.
    always @(posedge clk) begin
        bit   this_fire;
        bit   in_reset;
        exp_t e;
        this_fire = (bus_if.req_valid === 1'b1) && (reset === 1'b0);
        in_reset  = (reset === 1'b1);
        #1;
        chk("req_ready", 32'(bus_if.req_ready), 32'(!in_reset));
        if (bus_if.rsp_valid === 1'b1) dut_rel++;
        if (this_fire) begin
            if (exp_q.size() == 0) begin
                chk("exp_queue_underflow", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(e.rel));
                chk("err_dup", 32'(bus_if.err_dup), 32'(e.dup));
                if (e.rel) chk("rsp_id", 32'(bus_if.rsp_id), 32'(e.id));
            end
        end else begin
            chk("rsp_valid_idle", 32'(bus_if.rsp_valid), 32'(0));
            chk("err_dup_idle", 32'(bus_if.err_dup), 32'(0));
        end
    end

    initial begin
        int id, core;
        reset = 1'b1;
        bus_if.req_valid   = 1'b0;
        bus_if.req_id      = '0;
        bus_if.req_size_m1 = '0;
        bus_if.req_core_id = '0;
        model_clear();
        for (int b = 0; b < NB; b++) soak_size[b] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_id", 32'(bus_if.rsp_id), 32'(0));
        chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));

        // Basic: four cores on id 1, all bits of size_m1 set.
        arrive(1, 3, 0); arrive(1, 3, 2); arrive(1, 3, 3); arrive(1, 3, 1);
        idle(2);

        // Duplicate arrival on id 0.
        arrive(0, 1, 2); arrive(0, 1, 2); arrive(0, 1, 0);
        idle(2);

        // Interleaved IDs complete on consecutive cycles.
        arrive(0, 1, 0); arrive(3, 1, 0); arrive(3, 1, 1); arrive(0, 1, 1);
        idle(2);

        // Immediate releases, then an arrival during a release joins a new instance.
        arrive(2, 0, 1); arrive(2, 0, 1); arrive(2, 0, 1);
        arrive(2, 1, 0); arrive(2, 1, 3);
        idle(2);

        // Reset mid-barrier discards the partial mask.
        arrive(1, 2, 0); arrive(1, 2, 1);
        do_reset();
        arrive(1, 2, 2); arrive(1, 2, 0); arrive(1, 2, 1);
        idle(2);

        // A release pending in the output register is dropped by reset.
        arrive(3, 0, 2);
        do_reset();
        idle(2);

        // Random soak with a consistent size per barrier instance.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                id   = int'($urandom_range(0, NB - 1));
                core = int'($urandom_range(0, NC - 1));
                if (members(id) == 0) soak_size[id] = int'($urandom_range(0, NC - 1));
                arrive(id, soak_size[id], core);
            end
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        idle(3);

        chk("exp_queue_drained", 32'(exp_q.size()), 32'(0));
        chk("release_count", 32'(dut_rel), 32'(model_rel));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, errors %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
